// File: rtl/dff_share_pkg.sv
// Shared types and the round-robin pick function used by the register-sharing arbiters.
// rr_pick works on a fixed maximum width so that arbiters of any size up to RR_MAX_REQ can share it.
package dff_share_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = $clog2(RR_MAX_REQ);

    // One-hot pick of the first set req bit, searching ptr, ptr+1, ... modulo nreq (ptr < nreq).
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input int unsigned           ptr,
        input int unsigned           nreq
    );
        logic [RR_MAX_REQ-1:0] pick;
        logic                  found;
        int unsigned           idx;
        logic [RR_IDX_W-1:0]   sel;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            sel = RR_IDX_W'(idx);
            if ((k < nreq) && !found && req[sel]) begin
                pick[sel] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/Dff.sv
// Plain WIDTH-bit register with synchronous active-low clear; the team's storage primitive.
module Dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_share_arbiter_rr.sv
// Purely combinational round-robin arbiter: one-hot grant from a request vector and a start pointer.
module rr_arbiter
    import dff_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt
);

    logic [RR_MAX_REQ-1:0] req_ext;
    logic [RR_MAX_REQ-1:0] pick;
    logic                  unused_pick_hi;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        pick                = rr_pick(req_ext, 32'(ptr), unsigned'(NREQ));
        gnt                 = pick[NREQ-1:0];
    end

    // Bits above NREQ are never set because the search never leaves the first NREQ slots.
    assign unused_pick_hi = ^pick[RR_MAX_REQ-1:NREQ];

endmodule

// File: rtl/dff_share_arbiter.sv
// One shared Dff register loaded by NREQ requesters in round-robin order and drained by a valid/ready reader.
// A full register can be read and reloaded on the same edge, so a streaming reader sees no bubbles.
module dff_share_arbiter
    import dff_share_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WIDTH-1:0]  rd_data,
    output logic [IDW-1:0]    rd_owner
);

    state_e                 state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [NREQ-1:0]        arb_gnt;
    logic                   accept;
    logic                   wr_fire;
    logic [IDW-1:0]         wr_idx;
    logic [WIDTH-1:0]       wr_word;
    logic [IDW+WIDTH-1:0]   store_d, store_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    // Grants are suppressed during reset and whenever the slot cannot take a word this cycle.
    always_comb begin
        accept  = (state_q == EMPTY) || rd_ready;
        gnt     = (reset_n && accept) ? arb_gnt : '0;
        wr_fire = |(req & gnt);
        wr_idx  = '0;
        wr_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                wr_idx  = IDW'(i);
                wr_word = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        store_d = wr_fire ? {wr_idx, wr_word} : store_q;
        state_d = state_q;
        ptr_d   = ptr_q;
        if (wr_fire) begin
            state_d = FULL;
            ptr_d   = (wr_idx == IDW'(NREQ-1)) ? '0 : wr_idx + 1'b1;
        end else if ((state_q == FULL) && rd_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    Dff #(
        .WIDTH (IDW + WIDTH)
    ) u_store (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (store_d),
        .q       (store_q)
    );

    assign rd_valid = (state_q == FULL);
    assign rd_owner = store_q[IDW+WIDTH-1:WIDTH];
    assign rd_data  = store_q[WIDTH-1:0];

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter: grants are checked inline, read data through an expected-word queue.
module tb_dff_share_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [7:0]  rd_data;
    logic [1:0]  rd_owner;

    int checks = 0;
    int fails  = 0;
    logic [9:0] exp_q[$];

    dff_share_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_owner (rd_owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lanes(input logic [7:0] l3, input logic [7:0] l2,
                                          input logic [7:0] l1, input logic [7:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait for the falling edge to sample.
    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] wd, input logic rdy);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        req      = r;
        wdata    = wd;
        rd_ready = rdy;
        @(negedge clk);
    endtask

    task automatic resetDut(input int cycles, input logic [3:0] r);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            reset_n  = 1'b0;
            req      = r;
            wdata    = '0;
            rd_ready = 1'b0;
            exp_q.delete();
            @(negedge clk);
            checkOutput("gnt_in_reset", 32'(gnt), 32'h0);
        end
    endtask

    // Monitor: every read handshake must deliver the oldest outstanding expected word.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_read", 32'({rd_owner, rd_data}), 32'h3ff);
            end else begin
                checkOutput("read_word", 32'({rd_owner, rd_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with all requesters active, then check the cleared state.
        resetDut(2, 4'b1111);
        applyStimulus(4'b0000, '0, 1'b0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'h0);
        checkOutput("rst_rd_owner", 32'(rd_owner), 32'h0);
        checkOutput("idle_gnt", 32'(gnt), 32'h0);

        // Single write then read.
        applyStimulus(4'b0100, lanes(8'h00, 8'hA5, 8'h00, 8'h00), 1'b0);
        checkOutput("single_gnt", 32'(gnt), 32'h4);
        exp_q.push_back({2'd2, 8'hA5});
        applyStimulus(4'b0100, lanes(8'h00, 8'hA5, 8'h00, 8'h00), 1'b0);
        checkOutput("single_valid", 32'(rd_valid), 32'h1);
        checkOutput("single_data", 32'(rd_data), 32'hA5);
        checkOutput("single_owner", 32'(rd_owner), 32'h2);
        checkOutput("single_full_gnt", 32'(gnt), 32'h0);
        applyStimulus(4'b0000, '0, 1'b1);
        applyStimulus(4'b0000, '0, 1'b0);
        checkOutput("single_drained", 32'(rd_valid), 32'h0);

        // Round robin with wrap while streaming.
        resetDut(2, 4'b1111);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b1111, lanes(8'h13, 8'h12, 8'h11, 8'h10), 1'b1);
            checkOutput("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            exp_q.push_back({2'(k % 4), 8'(8'h10 + (k % 4))});
            if (k > 0) begin
                checkOutput("rr_no_bubble", 32'(rd_valid), 32'h1);
            end
        end
        applyStimulus(4'b0000, '0, 1'b1);
        applyStimulus(4'b0000, '0, 1'b0);
        checkOutput("rr_drained", 32'(rd_valid), 32'h0);

        // Backpressure: pointer is 2, so requester 0 wins first.
        applyStimulus(4'b0001, lanes(8'h00, 8'h00, 8'h00, 8'h5A), 1'b0);
        checkOutput("bp_first_gnt", 32'(gnt), 32'h1);
        exp_q.push_back({2'd0, 8'h5A});
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0010, lanes(8'h00, 8'h00, 8'h77, 8'h00), 1'b0);
            checkOutput("bp_hold_gnt", 32'(gnt), 32'h0);
            checkOutput("bp_hold_data", 32'(rd_data), 32'h5A);
        end
        applyStimulus(4'b0010, lanes(8'h00, 8'h00, 8'h77, 8'h00), 1'b1);
        checkOutput("bp_release_gnt", 32'(gnt), 32'h2);
        exp_q.push_back({2'd1, 8'h77});
        applyStimulus(4'b0000, '0, 1'b0);
        checkOutput("bp_owner", 32'(rd_owner), 32'h1);
        checkOutput("bp_data", 32'(rd_data), 32'h77);
        applyStimulus(4'b0000, '0, 1'b1);

        // Pointer skip: grant to 2 leaves ptr=3, so 0 beats 1, then ptr=1 favours 1.
        applyStimulus(4'b0100, lanes(8'h00, 8'hC3, 8'h00, 8'h00), 1'b0);
        checkOutput("skip_setup_gnt", 32'(gnt), 32'h4);
        exp_q.push_back({2'd2, 8'hC3});
        applyStimulus(4'b0011, lanes(8'h00, 8'h00, 8'h02, 8'h01), 1'b1);
        checkOutput("skip_gnt_wrap", 32'(gnt), 32'h1);
        exp_q.push_back({2'd0, 8'h01});
        applyStimulus(4'b0011, lanes(8'h00, 8'h00, 8'h02, 8'h01), 1'b1);
        checkOutput("skip_gnt_next", 32'(gnt), 32'h2);
        exp_q.push_back({2'd1, 8'h02});
        applyStimulus(4'b0000, '0, 1'b1);

        // Reset mid-operation from ptr=3: stored word is dropped and the search restarts at 0.
        applyStimulus(4'b0100, lanes(8'h00, 8'h3C, 8'h00, 8'h00), 1'b0);
        checkOutput("mid_setup_gnt", 32'(gnt), 32'h4);
        exp_q.push_back({2'd2, 8'h3C});
        applyStimulus(4'b0000, '0, 1'b0);
        checkOutput("mid_full_data", 32'(rd_data), 32'h3C);
        resetDut(1, 4'b0000);
        applyStimulus(4'b0000, '0, 1'b0);
        checkOutput("mid_rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("mid_rd_data", 32'(rd_data), 32'h0);
        checkOutput("mid_rd_owner", 32'(rd_owner), 32'h0);
        applyStimulus(4'b1001, lanes(8'h99, 8'h00, 8'h00, 8'h44), 1'b0);
        checkOutput("mid_ptr_zero_gnt", 32'(gnt), 32'h1);
        exp_q.push_back({2'd0, 8'h44});
        applyStimulus(4'b1000, lanes(8'h99, 8'h00, 8'h00, 8'h44), 1'b1);
        checkOutput("mid_gnt3", 32'(gnt), 32'h8);
        exp_q.push_back({2'd3, 8'h99});
        applyStimulus(4'b0000, '0, 1'b0);
        checkOutput("mid_owner3", 32'(rd_owner), 32'h3);
        applyStimulus(4'b0000, '0, 1'b1);
        applyStimulus(4'b0000, '0, 1'b0);
        checkOutput("final_valid", 32'(rd_valid), 32'h0);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
